// File: rtl/rf_pkg.sv
// Shared helpers for the parametrised RV32I register file:
// address-width and address-legality functions plus default sizes.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Addresses are at most 6 bits (NREG <= 64); 7 bits leaves headroom.
    function automatic logic addr_ok(
        input logic [6:0] a,
        input int         nreg,
        input int         zero_reg
    );
        return (int'(a) < nreg) && !((zero_reg != 0) && (a == 7'd0));
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: range check, register-0 forcing,
// writeback bypass and pending-producer flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   ra,
    input  logic            wr_en,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] data_write,
    input  logic            set_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic [XLEN-1:0] rf [NREG],
    input  logic [NREG-1:0] busy,
    output logic [XLEN-1:0] rd,
    output logic            rd_busy
);

    logic ok;
    logic hit;
    logic set_hit;

    always_comb begin
        ok      = addr_ok(7'(ra), NREG, ZERO_REG);
        hit     = (BYPASS != 0) && wr_en && (wa == ra);
        set_hit = set_en && (issue_rd == ra);
        rd      = '0;
        rd_busy = 1'b0;
        if (ok) begin
            rd      = hit ? data_write : rf[ra];
            // A clear only forwards when no newer producer issues alongside.
            rd_busy = busy[ra] && !(hit && !set_hit);
        end
    end

endmodule

// File: rtl/rf_sb_param.sv
// NREG x XLEN register file with NRD read ports, one write port,
// write-to-read bypass and a per-register busy scoreboard.
module rf_sb_param
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2_min1(NREG),
    localparam int CW      = $clog2(NREG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_write,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     data_write,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic [NREG-1:0]     busy_vec,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_q;
    logic            wr_en;
    logic            set_en;
    logic            inc;
    logic            dec;

    assign wr_en  = reg_write && addr_ok(7'(wa), NREG, ZERO_REG);
    assign set_en = issue_valid && addr_ok(7'(issue_rd), NREG, ZERO_REG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[wa] <= data_write;
        end
    end

    // Set is applied last so a newer producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_en)  busy_nxt[wa]       = 1'b0;
        if (set_en) busy_nxt[issue_rd] = 1'b1;
        inc = set_en && !busy_q[issue_rd];
        dec = wr_en && busy_q[wa] && !(set_en && (issue_rd == wa));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (inc && !dec)      cnt_q <= cnt_q + CW'(1);
            else if (dec && !inc) cnt_q <= cnt_q - CW'(1);
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        rf_read_port #(
            .XLEN     (XLEN),
            .NREG     (NREG),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .ra         (ra[k*AW +: AW]),
            .wr_en      (wr_en),
            .wa         (wa),
            .data_write (data_write),
            .set_en     (set_en),
            .issue_rd   (issue_rd),
            .rf         (rf_q),
            .busy       (busy_q),
            .rd         (rd[k*XLEN +: XLEN]),
            .rd_busy    (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_rf_sb_param.sv
// Directed bench: default config (bypass) and a 24-entry no-bypass
// instance share all inputs and are checked against hand values.
module tb_rf_sb_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic [4:0]  wa;
    logic [31:0] data_write;
    logic [4:0]  ra0, ra1;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  rdb_a, rdb_b;
    logic [31:0] bv_a;
    logic [23:0] bv_b;
    logic [5:0]  cnt_a;
    logic [4:0]  cnt_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rf_sb_param dut_a (
        .clk(clk), .rst(rst), .reg_write(reg_write), .wa(wa),
        .data_write(data_write), .ra({ra1, ra0}), .rd(rd_a),
        .rd_busy(rdb_a), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_vec(bv_a), .busy_cnt(cnt_a)
    );

    rf_sb_param #(.NREG(24), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .reg_write(reg_write), .wa(wa),
        .data_write(data_write), .ra({ra1, ra0}), .rd(rd_b),
        .rd_busy(rdb_b), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_vec(bv_b), .busy_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write   = 1'b0;
        issue_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; reg_write = 1'b0; wa = '0; data_write = '0;
        ra0 = '0; ra1 = '0; issue_valid = 1'b0; issue_rd = '0;
        #3;
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            ra1 = 5'(31 - a);
            #1;
            chk("rst_rd_a", rd_a, 64'(0));
            chk("rst_rdb_a", 64'(rdb_a), 64'(0));
            chk("rst_rd_b", rd_b, 64'(0));
        end
        chk("rst_cnt_a", 64'(cnt_a), 64'(0));
        chk("rst_bv_b", 64'(bv_b), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        step();

        reg_write = 1'b1; wa = 5'd5; data_write = 32'hDEADBEEF; ra0 = 5'd5;
        #1;
        chk("byp_a", 64'(rd_a[31:0]), 64'(32'hDEADBEEF));
        chk("nobyp_b", 64'(rd_b[31:0]), 64'(0));
        step(); idle();
        chk("wr5_a", 64'(rd_a[31:0]), 64'(32'hDEADBEEF));
        chk("wr5_b", 64'(rd_b[31:0]), 64'(32'hDEADBEEF));

        reg_write = 1'b1; wa = 5'd0; data_write = 32'h1234; ra0 = 5'd0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        chk("zero_byp_a", 64'(rd_a[31:0]), 64'(0));
        step(); idle();
        chk("zero_rd_a", 64'(rd_a[31:0]), 64'(0));
        chk("zero_bv_a", 64'(bv_a), 64'(0));
        chk("zero_cnt_a", 64'(cnt_a), 64'(0));

        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_rd = 5'd9;
        step(); idle();
        chk("iss2_cnt_a", 64'(cnt_a), 64'(2));
        chk("iss2_bv_a", 64'(bv_a), 64'(32'h0000_0280));
        chk("iss2_cnt_b", 64'(cnt_b), 64'(2));
        reg_write = 1'b1; wa = 5'd7; data_write = 32'd77; ra1 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("setclr_rdb_a", 64'(rdb_a[1]), 64'(1));
        step(); idle();
        chk("setclr_bv_a", 64'(bv_a), 64'(32'h0000_0280));
        chk("setclr_cnt_a", 64'(cnt_a), 64'(2));
        chk("setclr_cnt_b", 64'(cnt_b), 64'(2));
        chk("setclr_rd_a", 64'(rd_a[63:32]), 64'(77));

        issue_valid = 1'b1; issue_rd = 5'd3;
        step(); idle();
        chk("iss3_cnt_a", 64'(cnt_a), 64'(3));
        reg_write = 1'b1; wa = 5'd3; data_write = 32'hA5A5_0003; ra1 = 5'd3;
        #1;
        chk("wb3_rdb_a", 64'(rdb_a[1]), 64'(0));
        chk("wb3_rd_a", 64'(rd_a[63:32]), 64'(32'hA5A5_0003));
        chk("wb3_rdb_b", 64'(rdb_b[1]), 64'(1));
        chk("wb3_rd_b", 64'(rd_b[63:32]), 64'(0));
        step(); idle();
        chk("wb3_cnt_a", 64'(cnt_a), 64'(2));
        chk("wb3_bv_a", 64'(bv_a), 64'(32'h0000_0280));
        chk("wb3_cnt_b", 64'(cnt_b), 64'(2));
        chk("wb3_rdb1_b", 64'(rdb_b[1]), 64'(0));

        reg_write = 1'b1; wa = 5'd30; data_write = 32'hFFFF; ra0 = 5'd30;
        issue_valid = 1'b1; issue_rd = 5'd30;
        #1;
        chk("oor_rd_b", 64'(rd_b[31:0]), 64'(0));
        chk("r30_byp_a", 64'(rd_a[31:0]), 64'(32'hFFFF));
        step(); idle();
        chk("oor_rd2_b", 64'(rd_b[31:0]), 64'(0));
        chk("oor_cnt_b", 64'(cnt_b), 64'(2));
        chk("oor_bv_b", 64'(bv_b), 64'(24'h00_0280));
        chk("r30_cnt_a", 64'(cnt_a), 64'(3));
        chk("r30_rd_a", 64'(rd_a[31:0]), 64'(32'hFFFF));

        issue_valid = 1'b1; issue_rd = 5'd1;
        step();
        issue_rd = 5'd2;
        step(); idle();
        chk("five_cnt_a", 64'(cnt_a), 64'(5));
        chk("four_cnt_b", 64'(cnt_b), 64'(4));
        ra0 = 5'd5;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cnt_a", 64'(cnt_a), 64'(0));
        chk("arst_bv_a", 64'(bv_a), 64'(0));
        chk("arst_cnt_b", 64'(cnt_b), 64'(0));
        chk("arst_rd_a", 64'(rd_a[31:0]), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        reg_write = 1'b1; wa = 5'd5; data_write = 32'hCAFE;
        step(); idle();
        chk("post_rst_wr_b", 64'(rd_b[31:0]), 64'(32'hCAFE));
        chk("post_rst_wr_a", 64'(rd_a[31:0]), 64'(32'hCAFE));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
